ddr_refresh_sequencer: RTL and testbench



---
 rtl/ddr_refresh_sequencer.sv | 153 +++++++++++++++
 tb/tb_ddr_refresh_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_refresh_sequencer.sv
// DDR3 refresh sequencer: arbitrates the command bus between user sequencer and refresh.
// Optional back-to-back refresh bursts under `DDR_REFRESH_BURST_EN.
module ddr_refresh_sequencer #(
  parameter int unsigned TRP       = 6,
  parameter int unsigned TRFC      = 88,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rfsh_want,
  input  logic       rfsh_need,
  output logic       rfsh_grant,
  input  logic       user_req,
  input  logic       user_busy,
  output logic       user_grant,
  input  logic       bank_open,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       cmd_a10,
  output logic       rfsh_active
);

  // state    | meaning
  // IDLE     | user owns (or may own) the bus
  // DRAIN    | refresh pending, waiting for user sequence to finish
  // PREA     | precharge-all on the bus
  // WAIT_RP  | tRP countdown
  // REF      | refresh on the bus, grant pulse
  // WAIT_RFC | tRFC countdown
  typedef enum logic [2:0] {
    IDLE, DRAIN, PREA, WAIT_RP, REF, WAIT_RFC
  } state_t;

  localparam logic [2:0] CMD_PREA  = 3'b101;
  localparam logic [2:0] CMD_REF   = 3'b110;
  localparam logic [7:0] TRP_LOAD  = 8'(TRP - 1);
  localparam logic [7:0] TRFC_LOAD = 8'(TRFC - 1);
  localparam bit         SKIP_RP   = (TRP == 1);

  if (TRP < 1 || TRP > 256 || TRFC < 2 || TRFC > 256 || MAX_BURST < 1 || MAX_BURST > 15)
  begin : g_bad_params
    $error("ddr_refresh_sequencer: parameter out of range");
  end

  state_t     state, state_next;
  logic [7:0] timer, timer_next;
  logic       start;
  logic       tc;
  logic       user_grant_next;

`ifdef DDR_REFRESH_BURST_EN
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
  logic [3:0] burst_cnt, burst_cnt_next;
  logic       burst_go;

  assign burst_go = rfsh_want && (burst_cnt < BURST_LAST) && (rfsh_need || !user_req);
`endif

  assign start = rfsh_need || (rfsh_want && !user_req && !user_busy);
  // Terminal count: the down-counter reaches zero on this edge, so the next
  // command lands exactly TRP/TRFC cycles after the one that loaded it.
  assign tc    = (timer == 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= 8'd0;
      user_grant <= 1'b0;
`ifdef DDR_REFRESH_BURST_EN
      burst_cnt  <= 4'd0;
`endif
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      user_grant <= user_grant_next;
`ifdef DDR_REFRESH_BURST_EN
      burst_cnt  <= burst_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next      = state;
    timer_next      = timer;
    user_grant_next = (state == IDLE) && user_req && !rfsh_need && !start;
`ifdef DDR_REFRESH_BURST_EN
    burst_cnt_next  = burst_cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (user_busy)      state_next = DRAIN;
          else if (bank_open) state_next = PREA;
          else                state_next = REF;
        end
      end
      DRAIN: begin
        if (!user_busy) state_next = bank_open ? PREA : REF;
      end
      PREA: begin
        timer_next = TRP_LOAD;
        state_next = SKIP_RP ? REF : WAIT_RP;
      end
      WAIT_RP: begin
        timer_next = timer - 8'd1;
        if (tc) state_next = REF;
      end
      REF: begin
        timer_next = TRFC_LOAD;
        state_next = WAIT_RFC;
      end
      WAIT_RFC: begin
        timer_next = timer - 8'd1;
        if (tc) begin
`ifdef DDR_REFRESH_BURST_EN
          if (burst_go) begin
            state_next     = REF;
            burst_cnt_next = burst_cnt + 4'd1;
          end else begin
            state_next     = IDLE;
            burst_cnt_next = 4'd0;
          end
`else
          state_next = IDLE;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_valid   = 1'b0;
    cmd_code    = 3'b000;
    cmd_a10     = 1'b0;
    rfsh_grant  = 1'b0;
    rfsh_active = (state != IDLE);
    case (state)
      PREA: begin
        cmd_valid = 1'b1;
        cmd_code  = CMD_PREA;
        cmd_a10   = 1'b1;
      end
      REF: begin
        cmd_valid  = 1'b1;
        cmd_code   = CMD_REF;
        rfsh_grant = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr_refresh_sequencer.sv
// Self-checking bench for ddr_refresh_sequencer: expected commands are queued as
// stimulus is driven and matched against the bus by a negedge monitor.
module tb_ddr_refresh_sequencer;

  localparam int TRP       = 3;
  localparam int TRFC      = 10;
  localparam int MAX_BURST = 3;
`ifdef DDR_REFRESH_BURST_EN
  localparam int BL = MAX_BURST;
`else
  localparam int BL = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rfsh_want = 1'b0, rfsh_need = 1'b0, user_req = 1'b0, user_busy = 1'b0;
  logic       bank_open = 1'b0;
  logic       rfsh_grant, user_grant, cmd_valid, cmd_a10, rfsh_active;
  logic [2:0] cmd_code;

  ddr_refresh_sequencer #(.TRP(TRP), .TRFC(TRFC), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .rfsh_want(rfsh_want), .rfsh_need(rfsh_need), .rfsh_grant(rfsh_grant),
    .user_req(user_req), .user_busy(user_busy), .user_grant(user_grant),
    .bank_open(bank_open),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_a10(cmd_a10),
    .rfsh_active(rfsh_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] code;
    logic       a10;
    logic       grant;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push(input int c, input logic [2:0] code, input logic a10, input logic grant);
    exp_t e;
    e.cyc = c; e.code = code; e.a10 = a10; e.grant = grant;
    q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Command monitor: every command on the bus must match the next queued expectation.
  always @(negedge clk) begin
    if (cmd_valid) begin
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_cmd cyc=%0d code=%b a10=%b, expected no command", cyc, cmd_code, cmd_a10);
      end else begin
        mon_e = q.pop_front();
        vectors++;
        if (cyc !== mon_e.cyc || cmd_code !== mon_e.code || cmd_a10 !== mon_e.a10 ||
            rfsh_grant !== mon_e.grant) begin
          miscompares++;
          $display("FAIL cmd got cyc=%0d code=%b a10=%b grant=%b, expected cyc=%0d code=%b a10=%b grant=%b",
                   cyc, cmd_code, cmd_a10, rfsh_grant, mon_e.cyc, mon_e.code, mon_e.a10, mon_e.grant);
        end
      end
    end
    if (rfsh_grant && !(cmd_valid && cmd_code == 3'b110)) begin
      miscompares++;
      $display("FAIL grant_without_ref cyc=%0d cmd_valid=%b code=%b, expected REF with grant", cyc, cmd_valid, cmd_code);
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    wait_cycles(2);
    vectors++;
    if ({cmd_valid, cmd_code, cmd_a10, rfsh_grant, user_grant, rfsh_active} !== 8'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b expected 00000000",
               {cmd_valid, cmd_code, cmd_a10, rfsh_grant, user_grant, rfsh_active});
    end
    rfsh_want = 1'b1; user_req = 1'b1;
    wait_cycles(2);
    vectors++;
    if ({cmd_valid, user_grant, rfsh_active} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_hold got valid/ugrant/active=%b expected 000", {cmd_valid, user_grant, rfsh_active});
    end
    rfsh_want = 1'b0; user_req = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_ref;
    int k, c;
    k = cyc;
    rfsh_want = 1'b1;
    push(k + 1, 3'b110, 1'b0, 1'b1);
    wait_cycles(1);
    c = cyc;
    rfsh_want = 1'b0;
    user_req  = 1'b1;
    for (int i = 0; i <= TRFC; i++) begin
      vectors++;
      if (user_grant !== 1'b0 || rfsh_active !== (i < TRFC)) begin
        miscompares++;
        $display("FAIL single_hold off=%0d got ugrant=%b active=%b expected ugrant=0 active=%b",
                 i, user_grant, rfsh_active, (i < TRFC));
      end
      wait_cycles(1);
    end
    vectors++;
    if (user_grant !== 1'b1 || rfsh_active !== 1'b0) begin
      miscompares++;
      $display("FAIL single_release got ugrant=%b active=%b expected ugrant=1 active=0", user_grant, rfsh_active);
    end
    user_req = 1'b0;
    wait_cycles(2);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL single_drain pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_prea;
    int k;
    k = cyc;
    bank_open = 1'b1;
    rfsh_want = 1'b1;
    push(k + 1, 3'b101, 1'b1, 1'b0);
    push(k + 1 + TRP, 3'b110, 1'b0, 1'b1);
    wait_cycles(1);
    rfsh_want = 1'b0;
    bank_open = 1'b0;
    wait_cycles(TRP + TRFC + 2);
    vectors++;
    if (q.size() != 0 || rfsh_active !== 1'b0) begin
      miscompares++;
      $display("FAIL prea_drain pending=%0d active=%b expected 0 and 0", q.size(), rfsh_active);
      q.delete();
    end
  endtask

  task automatic test_user_wins;
    int d;
    rfsh_want = 1'b1;
    user_req  = 1'b1;
    wait_cycles(1);
    vectors++;
    if (user_grant !== 1'b1 || cmd_valid !== 1'b0 || rfsh_active !== 1'b0) begin
      miscompares++;
      $display("FAIL user_wins got ugrant=%b valid=%b active=%b expected 1 0 0", user_grant, cmd_valid, rfsh_active);
    end
    user_busy = 1'b1;
    user_req  = 1'b0;
    wait_cycles(2);
    vectors++;
    if (rfsh_active !== 1'b0) begin
      miscompares++;
      $display("FAIL want_while_busy got active=%b expected 0", rfsh_active);
    end
    rfsh_need = 1'b1;
    wait_cycles(1);
    vectors++;
    if (rfsh_active !== 1'b1 || user_grant !== 1'b0) begin
      miscompares++;
      $display("FAIL need_drain got active=%b ugrant=%b expected 1 0", rfsh_active, user_grant);
    end
    wait_cycles(2);
    d = cyc;
    user_busy = 1'b0;
    bank_open = 1'b1;
    push(d + 1, 3'b101, 1'b1, 1'b0);
    push(d + 1 + TRP, 3'b110, 1'b0, 1'b1);
    wait_cycles(1);
    rfsh_need = 1'b0;
    rfsh_want = 1'b0;
    bank_open = 1'b0;
    wait_cycles(TRP + TRFC + 2);
    vectors++;
    if (q.size() != 0 || rfsh_active !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_seq pending=%0d active=%b expected 0 and 0", q.size(), rfsh_active);
      q.delete();
    end
  endtask

  // Want held for four grants: REFs inside a burst are TRFC apart, a new
  // ownership costs one extra IDLE cycle.
  task automatic test_back_to_back;
    int k, c0;
    k = cyc;
    c0 = k + 1;
    rfsh_want = 1'b1;
    for (int i = 0; i < 4; i++) push(c0 + i * TRFC + i / BL, 3'b110, 1'b0, 1'b1);
    wait_cycles(3 * TRFC + 3 / BL + 1);
    rfsh_want = 1'b0;
    wait_cycles(TRFC + 3);
    vectors++;
    if (q.size() != 0 || rfsh_active !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back pending=%0d active=%b expected 0 and 0", q.size(), rfsh_active);
      q.delete();
    end
  endtask

  task automatic test_rst_mid;
    int k;
    k = cyc;
    bank_open = 1'b1;
    rfsh_want = 1'b1;
    push(k + 1, 3'b101, 1'b1, 1'b0);
    wait_cycles(2);
    vectors++;
    if (q.size() != 0 || rfsh_active !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_setup pending=%0d active=%b expected 0 and 1", q.size(), rfsh_active);
      q.delete();
    end
    rst = 1'b1;
    rfsh_want = 1'b0;
    bank_open = 1'b0;
    #1;
    vectors++;
    if ({cmd_valid, cmd_code, cmd_a10, rfsh_grant, user_grant, rfsh_active} !== 8'b0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs got %b expected 00000000",
               {cmd_valid, cmd_code, cmd_a10, rfsh_grant, user_grant, rfsh_active});
    end
    wait_cycles(1);
    rst = 1'b0;
    wait_cycles(TRP + TRFC + 3);
    vectors++;
    if (rfsh_active !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_idle got active=%b expected 0", rfsh_active);
    end
    k = cyc;
    rfsh_want = 1'b1;
    push(k + 1, 3'b110, 1'b0, 1'b1);
    wait_cycles(1);
    rfsh_want = 1'b0;
    wait_cycles(TRFC + 2);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL rst_mid_recover pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_ref();
    test_prea();
    test_user_wins();
    test_back_to_back();
    test_rst_mid();
    wait_cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d expected completion", cyc);
    $fatal(1);
  end

endmodule
